// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared half-precision FPU types plus issue-buffer state and queue-entry types.
package fpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int ZHINX_TAG_W = 5;
  typedef enum logic [2:0] {
    FPU_HALF_ADD,
    FPU_HALF_SUB,
    FPU_HALF_MUL,
    FPU_HALF_DIV,
    FPU_HALF_SQRT,
    FPU_HALF_MIN,
    FPU_HALF_MAX
  } fpu_operation_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} zhinx_issue_state_t;
  typedef struct packed {
    fpu_operation_t op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [ZHINX_TAG_W-1:0] tag;
  } zhinx_req_entry_t;
endpackage

// File: rtl/zhinx_req_fifo.sv
// zhinx_req_fifo: power-of-two request queue with occupancy count and synchronous flush.
module zhinx_req_fifo
  import fpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  zhinx_req_entry_t       wdata,
  output zhinx_req_entry_t       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  zhinx_req_entry_t mem [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr;
  assign rdata = mem[head_ptr];
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge CLK)
    if (push) mem[tail_ptr] <= wdata;
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop) head_ptr <= head_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/rv32zhinx_issue_buffer.sv
// rv32zhinx_issue_buffer: queues half-precision requests, sequences them into the FPU core, holds results for writeback.
module rv32zhinx_issue_buffer
  import fpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  fpu_operation_t         req_op,
  input  logic [WORD_W-1:0]      req_a,
  input  logic [WORD_W-1:0]      req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   fpu_start,
  output fpu_operation_t         fpu_operation,
  output logic [WORD_W-1:0]      fpu_a,
  output logic [WORD_W-1:0]      fpu_b,
  input  logic                   fpu_done,
  input  logic [WORD_W-1:0]      fpu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_W-1:0]      rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [$clog2(DEPTH):0] count
);
  zhinx_issue_state_t state, state_n;
  zhinx_req_entry_t wentry, head;
  logic full, empty, push, pop;
  assign req_ready = !full;
  assign push = req_valid && req_ready && !flush;
  assign pop  = state == ISSUE && fpu_done && !flush;
  assign wentry = '{op: req_op, a: req_a, b: req_b, tag: ZHINX_TAG_W'(req_tag)};
  zhinx_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .nRST(nRST), .flush(flush), .push(push), .pop(pop),
    .wdata(wentry), .rdata(head), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    fpu_start     = state == ISSUE;
    fpu_operation = fpu_start ? head.op : FPU_HALF_ADD;
    fpu_a         = fpu_start ? head.a : '0;
    fpu_b         = fpu_start ? head.b : '0;
    // RESP exit looks at the post-pop count plus any push landing this cycle
    state_n = flush ? IDLE :
              state == IDLE  ? (empty ? IDLE : ISSUE) :
              state == ISSUE ? (fpu_done ? RESP : ISSUE) :
              rsp_ready ? ((!empty || push) ? ISSUE : IDLE) : RESP;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      state <= state_n;
      if (flush) rsp_valid <= 1'b0;
      else if (pop) begin
        rsp_valid <= 1'b1;
        rsp_data  <= fpu_out;
        rsp_tag   <= TAG_W'(head.tag);
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
